// File: rtl/sdram_status_led.sv
// Status LED driver for the SDRAM tester: per-channel fault FSM with stretch or
// sticky hold, saturating error counters, and a shared free-running heartbeat.

module sdram_status_led_chan #(
   parameter int STRETCH_BITS = 28,
   parameter int COUNT_BITS   = 16,
   parameter int STICKY       = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ready,
   input  logic                  running,
   input  logic                  heartbeat,
   input  logic                  error,
   input  logic                  clear,
   output logic                  led,
   output logic [COUNT_BITS-1:0] count,
   output logic                  fault
);

   typedef enum logic [1:0] {ST_OK, ST_FLASH, ST_HELD} state_t;

   state_t                  state_q, state_d;
   logic [STRETCH_BITS-1:0] stretch_q, stretch_d;
   logic [COUNT_BITS-1:0]   count_q, count_d;
   logic                    led_q, led_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_OK;
         stretch_q <= '0;
         count_q   <= '0;
         led_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         stretch_q <= stretch_d;
         count_q   <= count_d;
         led_q     <= led_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stretch_d = stretch_q;
      count_d   = count_q;
      // Clear is applied first so a same-cycle error is still counted on top of it.
      if (clear) begin
         state_d   = ST_OK;
         stretch_d = '0;
         count_d   = '0;
      end
      if (error) begin
         if (count_d != '1) count_d = count_d + COUNT_BITS'(1);
         state_d   = (STICKY != 0) ? ST_HELD : ST_FLASH;
         stretch_d = '0;
      end else if (!clear) begin
         case (state_q)
            ST_FLASH: begin
               if (stretch_q == '1) begin
                  state_d   = ST_OK;
                  stretch_d = '0;
               end else begin
                  stretch_d = stretch_q + STRETCH_BITS'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign fault = (state_q != ST_OK);
   assign led_d = ready & (running ^ (fault & heartbeat));
   assign led   = led_q;
   assign count = count_q;

endmodule

module sdram_status_led #(
   parameter int CHANNELS     = 2,
   parameter int BLINK_BITS   = 24,
   parameter int STRETCH_BITS = 28,
   parameter int COUNT_BITS   = 16,
   parameter int STICKY       = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             ready,
   input  logic                             running,
   input  logic [CHANNELS-1:0]              error,
   input  logic                             clear,
   output logic [CHANNELS-1:0]              led,
   output logic [CHANNELS*COUNT_BITS-1:0]   errorCount,
   output logic                             anyFault,
   output logic                             heartbeat
);

   logic [BLINK_BITS-1:0] hb_q, hb_d;
   logic [CHANNELS-1:0]   fault;

   always_ff @(posedge clock) begin
      if (reset) hb_q <= '0;
      else       hb_q <= hb_d;
   end

   assign hb_d      = hb_q + BLINK_BITS'(1);
   assign heartbeat = hb_q[BLINK_BITS-1];
   assign anyFault  = |fault;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      sdram_status_led_chan #(
         .STRETCH_BITS (STRETCH_BITS),
         .COUNT_BITS   (COUNT_BITS),
         .STICKY       (STICKY)
      ) u_chan (
         .clock     (clock),
         .reset     (reset),
         .ready     (ready),
         .running   (running),
         .heartbeat (heartbeat),
         .error     (error[i]),
         .clear     (clear),
         .led       (led[i]),
         .count     (errorCount[i*COUNT_BITS +: COUNT_BITS]),
         .fault     (fault[i])
      );
   end

endmodule

// File: tb/tb_sdram_status_led.sv
// Randomized scoreboard bench: a STICKY=0 and a STICKY=1 instance share stimulus and
// are checked each cycle against an edge-count/timestamp reference model.

module tb_sdram_status_led;
   localparam int CH = 2;
   localparam int BB = 3;
   localparam int SB = 4;
   localparam int CB = 4;
   localparam int CMAX = (1 << CB) - 1;

   logic clock = 1'b0;
   logic reset, ready, running, clear;
   logic [CH-1:0] error;

   logic [CH-1:0]    led0, led1;
   logic [CH*CB-1:0] cnt0, cnt1;
   logic             af0, af1, hb0, hb1;

   typedef struct {
      logic [CH-1:0]    led0, led1;
      logic [CH*CB-1:0] cnt;
      logic             af0, af1, hb;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sdram_status_led #(.CHANNELS(CH), .BLINK_BITS(BB), .STRETCH_BITS(SB),
                      .COUNT_BITS(CB), .STICKY(0)) dut0 (
      .clock(clock), .reset(reset), .ready(ready), .running(running),
      .error(error), .clear(clear), .led(led0), .errorCount(cnt0),
      .anyFault(af0), .heartbeat(hb0));

   sdram_status_led #(.CHANNELS(CH), .BLINK_BITS(BB), .STRETCH_BITS(SB),
                      .COUNT_BITS(CB), .STICKY(1)) dut1 (
      .clock(clock), .reset(reset), .ready(ready), .running(running),
      .error(error), .clear(clear), .led(led1), .errorCount(cnt1),
      .anyFault(af1), .heartbeat(hb1));

   // Reference model: e counts edges since reset; a flash fault is live while fewer
   // than 2^SB edges have passed since the last error; a sticky fault until clear.
   initial begin
      int  e;
      int  last_err [CH];
      bit  has_err [CH];
      bit  held [CH];
      int  cnt [CH];
      bit  lm0 [CH];
      bit  lm1 [CH];
      bit  hb_old, f0, f1;
      exp_t x;
      e = 0;
      for (int c = 0; c < CH; c++) begin
         last_err[c] = 0; has_err[c] = 0; held[c] = 0; cnt[c] = 0; lm0[c] = 0; lm1[c] = 0;
      end
      forever begin
         @(posedge clock);
         if (reset) begin
            e = 0;
            for (int c = 0; c < CH; c++) begin
               has_err[c] = 0; held[c] = 0; cnt[c] = 0; lm0[c] = 0; lm1[c] = 0;
            end
         end else begin
            hb_old = ((e >> (BB - 1)) & 1) != 0;
            for (int c = 0; c < CH; c++) begin
               f0 = has_err[c] && ((e - last_err[c]) < (1 << SB));
               f1 = held[c];
               lm0[c] = ready & (running ^ (f0 & hb_old));
               lm1[c] = ready & (running ^ (f1 & hb_old));
            end
            e++;
            for (int c = 0; c < CH; c++) begin
               if (clear) begin
                  cnt[c] = 0; has_err[c] = 0; held[c] = 0;
               end
               if (error[c]) begin
                  cnt[c] = (cnt[c] < CMAX) ? cnt[c] + 1 : CMAX;
                  has_err[c] = 1; last_err[c] = e; held[c] = 1;
               end
            end
         end
         x.af0 = 0; x.af1 = 0;
         x.hb = ((e >> (BB - 1)) & 1) != 0;
         for (int c = 0; c < CH; c++) begin
            x.led0[c] = lm0[c];
            x.led1[c] = lm1[c];
            x.cnt[c*CB +: CB] = CB'(cnt[c]);
            x.af0 |= has_err[c] && ((e - last_err[c]) < (1 << SB));
            x.af1 |= held[c];
         end
         q.push_back(x);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: every edge the DUT presents new outputs; compare against the queue.
   initial begin
      exp_t x;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
         end else begin
            x = q.pop_front();
            chk("led_flash",   32'(led0), 32'(x.led0));
            chk("led_sticky",  32'(led1), 32'(x.led1));
            chk("cnt_flash",   32'(cnt0), 32'(x.cnt));
            chk("cnt_sticky",  32'(cnt1), 32'(x.cnt));
            chk("any_flash",   32'(af0),  32'(x.af0));
            chk("any_sticky",  32'(af1),  32'(x.af1));
            chk("hb_flash",    32'(hb0),  32'(x.hb));
            chk("hb_sticky",   32'(hb1),  32'(x.hb));
         end
      end
   end

   task automatic step(input logic [CH-1:0] err, input logic clr, input logic rst, input int n);
      for (int i = 0; i < n; i++) begin
         error = err; clear = clr; reset = rst;
         @(negedge clock);
      end
   endtask

   initial begin
      reset = 1'b1; ready = 1'b1; running = 1'b1; error = '0; clear = 1'b0;
      step(2'b00, 0, 1, 3);
      step(2'b00, 0, 0, 20);
      step(2'b01, 0, 0, 1);     // single pulse, full stretch
      step(2'b00, 0, 0, 25);
      step(2'b01, 0, 0, 1);     // retrigger mid-stretch
      step(2'b00, 0, 0, 9);
      step(2'b01, 0, 0, 1);
      step(2'b00, 0, 0, 30);
      step(2'b10, 0, 0, 20);    // saturation
      step(2'b00, 0, 0, 10);
      step(2'b00, 1, 0, 1);
      step(2'b00, 0, 0, 5);
      step(2'b01, 0, 0, 1);
      step(2'b00, 0, 0, 100);   // sticky hold
      step(2'b00, 1, 0, 1);
      step(2'b00, 0, 0, 3);
      step(2'b01, 1, 0, 1);     // clear and error together
      step(2'b00, 0, 0, 5);
      step(2'b00, 1, 0, 1);
      step(2'b01, 0, 0, 1);
      step(2'b00, 0, 0, 6);
      step(2'b00, 0, 1, 1);     // mid-stretch reset
      ready = 1'b0;
      step(2'b01, 0, 0, 1);
      step(2'b00, 0, 0, 5);
      ready = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         logic [CH-1:0] err;
         for (int c = 0; c < CH; c++) err[c] = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 29) == 0) running = ~running;
         if ($urandom_range(0, 49) == 0) ready = ~ready;
         step(err, $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0, 1);
      end
      step(2'b00, 0, 0, 2);
      @(posedge clock);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
